// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loader_pkg
//  Purpose  : Shared definitions for the program loader: the state-register
//             width and the LEN/LOAD/CSUM/RUN/ERR state encodings.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] LEN  = 3'd0;  // waiting for the length byte
  localparam logic [STATE_W-1:0] LOAD = 3'd1;  // writing data bytes to memory
  localparam logic [STATE_W-1:0] CSUM = 3'd2;  // waiting for the checksum byte
  localparam logic [STATE_W-1:0] RUN  = 3'd3;  // processor owns the memory bus
  localparam logic [STATE_W-1:0] ERR  = 3'd4;  // checksum mismatch, held

endpackage : loader_pkg
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Boot loader. It accepts a byte stream (length N, then N data
//             bytes, then optionally a checksum byte) and writes the data
//             bytes to memory at addresses 0..N-1 while holding the processor
//             in reset. It then releases the processor and hands it the memory
//             bus. A length of 0 means 2^WIDTH bytes.
//  Config   : `define LOADER_CHECKSUM_EN adds a trailing checksum byte. It is
//             the modulo-2^WIDTH sum of the data bytes. A mismatch parks the
//             loader in ERR.
//  Ports    : clk, rst                    - clock, synchronous active-high reset
//             in_valid, in_data, in_ready - loader byte stream (valid/ready)
//             cpu_memread, cpu_memwrite,
//             cpu_adr, cpu_writedata      - processor memory request
//             mem_read, mem_we,
//             mem_adr, mem_wdata          - memory port
//             cpu_rst                     - processor reset (high until RUN)
//             done, err                   - load complete / load failed
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             cpu_memread,
  input  logic             cpu_memwrite,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_writedata,
  output logic             mem_read,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cpu_rst,
  output logic             done,
  output logic             err
);
  import loader_pkg::*;

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [STATE_W-1:0] r_state;
  logic [WIDTH-1:0]   r_len;
  logic [WIDTH-1:0]   r_count;
  logic               w_accept;
  logic               w_last;
`ifdef LOADER_CHECKSUM_EN
  logic [WIDTH-1:0]   r_csum;
`endif

  assign in_ready = (r_state == LEN) || (r_state == LOAD) || (r_state == CSUM);

  // Reset overrides a byte presented on the same edge. Nothing is accepted
  // and nothing is written.
  assign w_accept = in_valid & in_ready & ~rst;

  // The final byte is the one at index N-1. N=0 wraps to all-ones, so it
  // selects the 2^WIDTH-byte transfer without a separate case.
  assign w_last = (r_count == (r_len - c_one));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LEN;
      r_len   <= '0;
      r_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      case (r_state)
        LEN: begin
          if (w_accept) begin
            r_len   <= in_data;
            r_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_count <= r_count + c_one;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum + in_data;
            if (w_last) r_state <= CSUM;
`else
            if (w_last) r_state <= RUN;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (w_accept) r_state <= (in_data == r_csum) ? RUN : ERR;
        end
`endif
        default: ;  // RUN and ERR are left only through rst
      endcase
    end
  end

  // Memory bus mux. The loader drives writes during LOAD. The processor drives
  // the bus with zero latency in RUN. Everything else is idle.
  always_comb begin
    mem_read  = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    if (r_state == LOAD) begin
      if (w_accept) begin
        mem_we    = 1'b1;
        mem_adr   = r_count;
        mem_wdata = in_data;
      end
    end else if ((r_state == RUN) && !rst) begin
      mem_read  = cpu_memread;
      mem_we    = cpu_memwrite;
      mem_adr   = cpu_adr;
      mem_wdata = cpu_writedata;
    end
  end

  // Decoded from the state register only, so there is no combinational path
  // from any input.
  assign cpu_rst = (r_state != RUN);
  assign done    = (r_state == RUN);
`ifdef LOADER_CHECKSUM_EN
  assign err     = (r_state == ERR);
`else
  assign err     = 1'b0;
`endif

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader
//  Purpose  : Directed self-checking bench for prog_loader (WIDTH=8).
//             Inputs change 1 ns after the rising edge. Outputs are checked
//             2 ns after the rising edge, well before the next edge.
//  Config   : honours LOADER_CHECKSUM_EN (adds checksum scenarios).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             cpu_memread, cpu_memwrite;
  logic [WIDTH-1:0] cpu_adr, cpu_writedata;
  logic             mem_read, mem_we;
  logic [WIDTH-1:0] mem_adr, mem_wdata;
  logic             cpu_rst, done, err;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mon_adr[$];
  logic [WIDTH-1:0] mon_dat[$];

  prog_loader #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
    .mem_read(mem_read), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every write strobe that the memory would see on a rising edge.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mon_adr.push_back(mem_adr);
      mon_dat.push_back(mem_wdata);
    end
  end

  // Move to 1 ns after the next rising edge.
  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Drive the stream inputs, then let combinational outputs settle.
  task automatic present(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_data  = d;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    advance();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cpu_memwrite = 1'b1; cpu_memread = 1'b1;
    cpu_adr = 8'h12; cpu_writedata = 8'h34;
    do_reset();
    present(1'b0, 8'h00);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
    checks++; if (mem_we !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_strobes (cpu ignored): got we=%b rd=%b want 0 0", mem_we, mem_read); end
    cpu_memwrite = 1'b0; cpu_memread = 1'b0;
  endtask

  task automatic test_basic_load();
    logic [WIDTH-1:0] bytes [3];
    bytes = '{8'h11, 8'h22, 8'h33};
    do_reset();
    present(1'b1, 8'h03);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL basic_len_no_write: got we=%b want 0", mem_we); end
    advance();
    for (int i = 0; i < 3; i++) begin
      present(1'b1, bytes[i]);
      checks++;
      if (mem_we !== 1'b1 || mem_adr !== 8'(i) || mem_wdata !== bytes[i]) begin
        errors++;
        $display("FAIL basic_write%0d: got we=%b adr=%h dat=%h want 1 %h %h", i, mem_we, mem_adr, mem_wdata, 8'(i), bytes[i]);
      end
      checks++; if (done !== 1'b0 || cpu_rst !== 1'b1) begin errors++; $display("FAIL basic_not_done%0d: got done=%b cpu_rst=%b want 0 1", i, done, cpu_rst); end
      advance();
    end
    present(1'b0, 8'h00);
    checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL basic_run: got done=%b cpu_rst=%b want 1 0", done, cpu_rst); end
    checks++; if (in_ready !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL basic_run_ready: got in_ready=%b err=%b want 0 0", in_ready, err); end
  endtask

  // Expects the DUT to already be in RUN.
  task automatic test_run_bus();
    cpu_adr = 8'h40; cpu_memwrite = 1'b1; cpu_writedata = 8'hA5; cpu_memread = 1'b0;
    present(1'b1, 8'h77);
    checks++;
    if (mem_adr !== 8'h40 || mem_we !== 1'b1 || mem_wdata !== 8'hA5 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL run_write_pass: got adr=%h we=%b dat=%h rd=%b want 40 1 a5 0", mem_adr, mem_we, mem_wdata, mem_read);
    end
    cpu_adr = 8'h9C; cpu_memwrite = 1'b0; cpu_memread = 1'b1; cpu_writedata = 8'h00;
    #1;
    checks++;
    if (mem_adr !== 8'h9C || mem_we !== 1'b0 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL run_read_pass: got adr=%h we=%b rd=%b want 9c 0 1", mem_adr, mem_we, mem_read);
    end
    advance();
    advance();
    checks++; if (done !== 1'b1 || cpu_rst !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL run_hold: got done=%b cpu_rst=%b in_ready=%b want 1 0 0", done, cpu_rst, in_ready); end
    cpu_memread = 1'b0; cpu_adr = 8'h00;
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midload();
    do_reset();
    present(1'b1, 8'h03); advance();
    present(1'b1, 8'h11); advance();
    present(1'b1, 8'h22); advance();
    rst = 1'b1;
    present(1'b1, 8'h33);
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midrst_no_write: got we=%b want 0", mem_we); end
    advance();
    rst = 1'b0;
    present(1'b0, 8'h00);
    checks++; if (in_ready !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL midrst_state: got in_ready=%b cpu_rst=%b done=%b want 1 1 0", in_ready, cpu_rst, done); end
    present(1'b1, 8'h02); advance();
    present(1'b1, 8'hAA);
    checks++; if (mem_we !== 1'b1 || mem_adr !== 8'h00 || mem_wdata !== 8'hAA) begin errors++; $display("FAIL midrst_fresh0: got we=%b adr=%h dat=%h want 1 00 aa", mem_we, mem_adr, mem_wdata); end
    advance();
    present(1'b1, 8'hBB);
    checks++; if (mem_we !== 1'b1 || mem_adr !== 8'h01 || mem_wdata !== 8'hBB) begin errors++; $display("FAIL midrst_fresh1: got we=%b adr=%h dat=%h want 1 01 bb", mem_we, mem_adr, mem_wdata); end
    advance();
`ifdef LOADER_CHECKSUM_EN
    present(1'b1, 8'h65); advance();  // AA+BB = 0x165
`endif
    present(1'b0, 8'h00);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done: got %b want 1", done); end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] bytes [4];
    int k;
    bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
    do_reset();
    present(1'b1, 8'h04); advance();
    mon_adr.delete(); mon_dat.delete();
    k = 0;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) begin
        present(1'b1, bytes[k]);
        k++;
      end else begin
        present(1'b0, 8'hEE);
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL stall_idle%0d: got we=%b want 0", c, mem_we); end
      end
      advance();
    end
`ifdef LOADER_CHECKSUM_EN
    present(1'b1, 8'hA0); advance();
`endif
    present(1'b0, 8'h00);
    checks++; if (mon_adr.size() !== 4) begin errors++; $display("FAIL stall_count: got %0d writes want 4", mon_adr.size()); end
    for (int i = 0; i < 4 && i < mon_adr.size(); i++) begin
      checks++;
      if (mon_adr[i] !== 8'(i) || mon_dat[i] !== bytes[i]) begin
        errors++;
        $display("FAIL stall_write%0d: got adr=%h dat=%h want %h %h", i, mon_adr[i], mon_dat[i], 8'(i), bytes[i]);
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done); end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] sum;
    int bad;
    sum = 8'h00;
    do_reset();
    present(1'b1, 8'h00); advance();
    mon_adr.delete(); mon_dat.delete();
    for (int i = 0; i < 256; i++) begin
      present(1'b1, 8'(i) ^ 8'h5A);
      sum = sum + (8'(i) ^ 8'h5A);
      if (i == 255) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wrap_early_done: got %b want 0", done); end
      end
      advance();
    end
`ifdef LOADER_CHECKSUM_EN
    present(1'b1, sum); advance();
`endif
    present(1'b0, 8'h00);
    checks++; if (mon_adr.size() !== 256) begin errors++; $display("FAIL wrap_count: got %0d writes want 256", mon_adr.size()); end
    bad = 0;
    for (int i = 0; i < mon_adr.size(); i++)
      if (mon_adr[i] !== 8'(i) || mon_dat[i] !== (8'(i) ^ 8'h5A)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_writes: got %0d bad writes want 0", bad); end
    checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin errors++; $display("FAIL wrap_run: got done=%b cpu_rst=%b want 1 0", done, cpu_rst); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    present(1'b1, 8'h02); advance();
    present(1'b1, 8'h05); advance();
    present(1'b1, 8'h07); advance();
    present(1'b1, 8'h0C);
    checks++; if (mem_we !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL csum_no_write: got we=%b in_ready=%b want 0 1", mem_we, in_ready); end
    advance();
    present(1'b0, 8'h00);
    checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL csum_good: got done=%b err=%b want 1 0", done, err); end
    do_reset();
    present(1'b1, 8'h02); advance();
    present(1'b1, 8'h05); advance();
    present(1'b1, 8'h07); advance();
    present(1'b1, 8'h0D); advance();
    present(1'b1, 8'h00);
    checks++; if (err !== 1'b1 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL csum_bad: got err=%b cpu_rst=%b in_ready=%b done=%b want 1 1 0 0", err, cpu_rst, in_ready, done); end
    advance();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL csum_err_hold: got %b want 1", err); end
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    cpu_memread = 1'b0; cpu_memwrite = 1'b0; cpu_adr = '0; cpu_writedata = '0;
    #1;
    test_reset();
    test_basic_load();
    test_run_bus();
    test_reset_midload();
    test_stall();
    test_wrap();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_prog_loader
`default_nettype wire
